// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the multi-cycle control unit:
// opcodes, ALU op codes, pc_sel codes, FSM states, opcode classes.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_ST  = 7'h23;
    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_LD,
        CL_ST,
        CL_BR,
        CL_JAL,
        CL_BAD
    } cls_e;

    typedef struct packed {
        logic       ir_load;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       reg_write;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem2reg;
        logic       trap;
    } ctl_t;

    function automatic cls_e classify(input logic [6:0] op);
        case (op)
            OP_R:    return CL_R;
            OP_I:    return CL_I;
            OP_LD:   return CL_LD;
            OP_ST:   return CL_ST;
            OP_BR:   return CL_BR;
            OP_JAL:  return CL_JAL;
            default: return CL_BAD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bus between the control unit and the datapath/memory.
// master: controller (takes ins/zero/mem_ready, drives controls);
// slave: datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [31:0]      ins;
    logic             zero;
    logic             mem_ready;
    logic             ir_load;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             reg_write;
    logic             alu_src;
    logic [2:0]       alu_op;
    logic             mem_read;
    logic             mem_write;
    logic             mem2reg;
    logic             trap;
    logic [CNT_W-1:0] retired;

    modport master (
        input  ins, zero, mem_ready,
        output ir_load, pc_write, pc_sel, reg_write,
        output alu_src, alu_op, mem_read, mem_write,
        output mem2reg, trap, retired
    );

    modport slave (
        output ins, zero, mem_ready,
        input  ir_load, pc_write, pc_sel, reg_write,
        input  alu_src, alu_op, mem_read, mem_write,
        input  mem2reg, trap, retired
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decode.sv
// Combinational ALU op decode from opcode class and funct bits.
// Ports: cls, funct3, funct7b5 in; alu_op, illegal out.
module mc_alu_decode
    import multicycle_ctrl_pkg::*;
(
    input  cls_e       cls,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (cls)
            CL_R, CL_I: begin
                case (funct3)
                    3'b000: begin
                        // funct7[5] means sub only for register ops;
                        // for I-ALU that bit belongs to the immediate
                        if (cls == CL_R && funct7b5)
                            alu_op = ALU_SUB;
                        else
                            alu_op = ALU_ADD;
                    end
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            CL_BR:   alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait
// states, bus-timeout and illegal-instruction traps, retire counter.
// Ports: clk, rst (async, active-high); bus (master modport) carrying
// ins/zero/mem_ready in and all control outputs, trap, retired out.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    // Last allowed low-ready cycle: counter holds MEM_WAIT_MAX-1 there
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_e           state;
    state_e           state_n;
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic             f7b5;
    logic [7:0]       wcnt;
    logic [CNT_W-1:0] retired_q;

    cls_e       cls;
    logic [2:0] dec_op;
    logic       dec_ill;
    logic       wait_hit;
    logic       in_wait;
    ctl_t       ctl;
    ctl_t       ctl_o;

    logic unused_ins;
    assign unused_ins = ^{bus.ins[31], bus.ins[29:15], bus.ins[11:7]};

    assign cls = classify(opc);

    mc_alu_decode u_dec (
        .cls      (cls),
        .funct3   (f3),
        .funct7b5 (f7b5),
        .alu_op   (dec_op),
        .illegal  (dec_ill)
    );

    assign in_wait  = (state == S_FETCH) || (state == S_MEM);
    assign wait_hit = !bus.mem_ready && (wcnt == WAIT_LAST);

    always_comb begin
        state_n = state;
        ctl     = '0;
        unique case (state)
            S_FETCH: begin
                ctl.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ctl.ir_load = 1'b1;
                    state_n     = S_DECODE;
                end else if (wait_hit) begin
                    state_n = S_TRAP;
                end
            end
            S_DECODE: begin
                state_n = (cls == CL_BAD) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                ctl.alu_src = !(cls == CL_R || cls == CL_BR);
                if (dec_ill) begin
                    state_n = S_TRAP;
                end else begin
                    ctl.alu_op = dec_op;
                    case (cls)
                        CL_BR: begin
                            ctl.pc_write = 1'b1;
                            ctl.pc_sel   = bus.zero ? PC_BR : PC_SEQ;
                            state_n      = S_FETCH;
                        end
                        CL_LD, CL_ST: state_n = S_MEM;
                        default:      state_n = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (cls == CL_ST)
                    ctl.mem_write = 1'b1;
                else
                    ctl.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    if (cls == CL_ST) begin
                        ctl.pc_write = 1'b1;
                        ctl.pc_sel   = PC_SEQ;
                        state_n      = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (wait_hit) begin
                    state_n = S_TRAP;
                end
            end
            S_WB: begin
                ctl.reg_write = 1'b1;
                ctl.mem2reg   = (cls == CL_LD);
                ctl.pc_write  = 1'b1;
                ctl.pc_sel    = (cls == CL_JAL) ? PC_JMP : PC_SEQ;
                state_n       = S_FETCH;
            end
            S_TRAP: begin
                ctl.trap = 1'b1;
            end
            default: begin
                state_n = S_TRAP;
            end
        endcase
    end

    // Gate with rst so nothing escapes in the reset cycle itself,
    // including the one in which an instruction is aborted
    assign ctl_o = rst ? '0 : ctl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            opc       <= '0;
            f3        <= '0;
            f7b5      <= 1'b0;
            wcnt      <= '0;
            retired_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_FETCH && bus.mem_ready) begin
                opc  <= bus.ins[6:0];
                f3   <= bus.ins[14:12];
                f7b5 <= bus.ins[30];
            end
            // Cleared on any state change, so FETCH/MEM start at zero
            if (state_n != state)
                wcnt <= '0;
            else if (in_wait && !bus.mem_ready)
                wcnt <= wcnt + 8'd1;
            if (ctl_o.pc_write)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.ir_load   = ctl_o.ir_load;
    assign bus.pc_write  = ctl_o.pc_write;
    assign bus.pc_sel    = ctl_o.pc_sel;
    assign bus.reg_write = ctl_o.reg_write;
    assign bus.alu_src   = ctl_o.alu_src;
    assign bus.alu_op    = ctl_o.alu_op;
    assign bus.mem_read  = ctl_o.mem_read;
    assign bus.mem_write = ctl_o.mem_write;
    assign bus.mem2reg   = ctl_o.mem2reg;
    assign bus.trap      = ctl_o.trap;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control
// vectors are queued with their stimulus and checked as they play out.
module tb_multicycle_ctrl;

    localparam int CNT_W = 2;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ANDI = 32'h0070F093;
    localparam logic [31:0] I_LW   = 32'h00402283;
    localparam logic [31:0] I_SW   = 32'h00102023;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_ILL  = 32'h00000000;
    localparam logic [31:0] I_SLL  = 32'h002091B3;

    logic clk;
    logic rst;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(
        .MEM_WAIT_MAX (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nasserts = 0;
    int nfail    = 0;

    logic [31:0] q_ins[$];
    logic        q_z[$];
    logic        q_r[$];
    logic [12:0] q_e[$];
    logic [12:0] q_m[$];

    // {ir_load,pc_write,pc_sel,reg_write,alu_src,alu_op,
    //  mem_read,mem_write,mem2reg,trap}
    function automatic logic [12:0] v(
        input logic il, input logic pw, input logic [1:0] ps,
        input logic rw, input logic as, input logic [2:0] op,
        input logic mr, input logic mw, input logic m2r,
        input logic tr);
        return {il, pw, ps, rw, as, op, mr, mw, m2r, tr};
    endfunction

    function automatic logic [12:0] obs();
        return {bus.ir_load, bus.pc_write, bus.pc_sel,
                bus.reg_write, bus.alu_src, bus.alu_op,
                bus.mem_read, bus.mem_write, bus.mem2reg, bus.trap};
    endfunction

    logic [12:0] ALL, NOOP, FET, FWT, DEC, TRP, MRD, MWR, MWW;

    task automatic chk_v(input string tag, input logic [12:0] o,
                         input logic [12:0] e, input logic [12:0] m);
        nasserts++;
        assert ((o & m) === (e & m)) else begin
            nfail++;
            $error("FAIL %s observed=%b expected=%b mask=%b",
                   tag, o, e, m);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        nasserts++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic z,
                        input logic r, input logic [12:0] e,
                        input logic [12:0] m);
        q_ins.push_back(i);
        q_z.push_back(z);
        q_r.push_back(r);
        q_e.push_back(e);
        q_m.push_back(m);
    endtask

    task automatic p(input logic [31:0] i, input logic r,
                     input logic [12:0] e);
        push(i, 1'b0, r, e, ALL);
    endtask

    // Plays the queued cycles; entered just after a rising edge
    task automatic drain(input string tag);
        int n = 0;
        logic [12:0] e;
        logic [12:0] m;
        while (q_e.size() > 0) begin
            bus.ins       = q_ins.pop_front();
            bus.zero      = q_z.pop_front();
            bus.mem_ready = q_r.pop_front();
            e = q_e.pop_front();
            m = q_m.pop_front();
            @(negedge clk);
            chk_v($sformatf("%s[%0d]", tag, n), obs(), e, m);
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.ins       = I_ADD;
        @(negedge clk);
        chk_v({tag, "_outs"}, obs(), NOOP, ALL);
        chk({tag, "_ret"}, 32'(bus.retired), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({tag, "_trap"}, 32'(bus.trap), 0);
    endtask

    task automatic p_ex(input logic [31:0] i, input logic as,
                        input logic [2:0] op);
        p(i, 1'b1, v(0, 0, 2'b00, 0, as, op, 0, 0, 0, 0));
    endtask

    task automatic p_wb(input logic [31:0] i, input logic [1:0] ps,
                        input logic m2r);
        p(i, 1'b1, v(0, 1, ps, 1, 0, 3'b000, 0, 0, m2r, 0));
    endtask

    task automatic p_sw();
        p(I_SW, 1'b1, FET);
        p(I_SW, 1'b1, DEC);
        p_ex(I_SW, 1'b1, 3'b010);
        p(I_SW, 1'b1, MWR);
    endtask

    initial begin
        ALL  = '1;
        NOOP = '0;
        FET  = v(1, 0, 2'b00, 0, 0, 3'b000, 1, 0, 0, 0);
        FWT  = v(0, 0, 2'b00, 0, 0, 3'b000, 1, 0, 0, 0);
        DEC  = '0;
        TRP  = v(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 1);
        MRD  = v(0, 0, 2'b00, 0, 0, 3'b000, 1, 0, 0, 0);
        MWR  = v(0, 1, 2'b00, 0, 0, 3'b000, 0, 1, 0, 0);
        MWW  = v(0, 0, 2'b00, 0, 0, 3'b000, 0, 1, 0, 0);

        rst           = 1'b1;
        bus.ins       = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset("reset");

        // add x3,x1,x2
        p(I_ADD, 1'b1, FET);
        p(I_ADD, 1'b1, DEC);
        p_ex(I_ADD, 1'b0, 3'b010);
        p_wb(I_ADD, 2'b00, 1'b0);
        drain("add");
        chk("add_ret", 32'(bus.retired), 1);

        // lw with three wait cycles in MEM
        p(I_LW, 1'b1, FET);
        p(I_LW, 1'b1, DEC);
        p_ex(I_LW, 1'b1, 3'b010);
        p(I_LW, 1'b0, MRD);
        p(I_LW, 1'b0, MRD);
        p(I_LW, 1'b0, MRD);
        p(I_LW, 1'b1, MRD);
        p_wb(I_LW, 2'b00, 1'b1);
        drain("lw");
        chk("lw_ret", 32'(bus.retired), 2);

        // beq taken then not taken
        push(I_BEQ, 1'b1, 1'b1, FET, ALL);
        push(I_BEQ, 1'b1, 1'b1, DEC, ALL);
        push(I_BEQ, 1'b1, 1'b1,
             v(0, 1, 2'b01, 0, 0, 3'b110, 0, 0, 0, 0), ALL);
        drain("beq_t");
        chk("beq_t_ret", 32'(bus.retired), 3);
        p(I_BEQ, 1'b1, FET);
        p(I_BEQ, 1'b1, DEC);
        p(I_BEQ, 1'b1, v(0, 1, 2'b00, 0, 0, 3'b110, 0, 0, 0, 0));
        drain("beq_n");
        chk("beq_n_ret_wrap", 32'(bus.retired), 0);

        // jal: alu_op in EXEC is not pinned down, so it is masked
        p(I_JAL, 1'b1, FET);
        p(I_JAL, 1'b1, DEC);
        push(I_JAL, 1'b0, 1'b1,
             v(0, 0, 2'b00, 0, 1, 3'b000, 0, 0, 0, 0),
             ~v(0, 0, 2'b00, 0, 0, 3'b111, 0, 0, 0, 0));
        p_wb(I_JAL, 2'b10, 1'b0);
        drain("jal");
        chk("jal_ret", 32'(bus.retired), 1);

        p(I_SUB, 1'b1, FET);
        p(I_SUB, 1'b1, DEC);
        p_ex(I_SUB, 1'b0, 3'b110);
        p_wb(I_SUB, 2'b00, 1'b0);
        drain("sub");

        p(I_ANDI, 1'b1, FET);
        p(I_ANDI, 1'b1, DEC);
        p_ex(I_ANDI, 1'b1, 3'b000);
        p_wb(I_ANDI, 2'b00, 1'b0);
        drain("andi");
        chk("andi_ret", 32'(bus.retired), 3);

        // illegal opcode: trap from the cycle after DECODE
        p(I_ILL, 1'b1, FET);
        p(I_ILL, 1'b1, DEC);
        for (int i = 0; i < 10; i++) p(I_ADD, 1'b1, TRP);
        drain("ill_op");
        chk("ill_op_ret", 32'(bus.retired), 3);
        do_reset("ill_op_rst");

        // illegal funct3 on an R-type traps out of EXEC
        p(I_SLL, 1'b1, FET);
        p(I_SLL, 1'b1, DEC);
        push(I_SLL, 1'b0, 1'b1, NOOP,
             ~v(0, 0, 2'b00, 0, 0, 3'b111, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) p(I_ADD, 1'b1, TRP);
        drain("ill_f3");
        chk("ill_f3_ret", 32'(bus.retired), 0);
        do_reset("ill_f3_rst");

        // fetch timeout after 4 low cycles
        for (int i = 0; i < 4; i++) p(I_ADD, 1'b0, FWT);
        for (int i = 0; i < 3; i++) p(I_ADD, 1'b0, TRP);
        drain("fto");
        do_reset("fto_rst");

        // ready on the limit cycle wins
        for (int i = 0; i < 3; i++) p(I_ADD, 1'b0, FWT);
        p(I_ADD, 1'b1, FET);
        p(I_ADD, 1'b1, DEC);
        p_ex(I_ADD, 1'b0, 3'b010);
        p_wb(I_ADD, 2'b00, 1'b0);
        drain("flim");
        chk("flim_ret", 32'(bus.retired), 1);

        // MEM timeout on a load: no retire
        p(I_LW, 1'b1, FET);
        p(I_LW, 1'b1, DEC);
        p_ex(I_LW, 1'b1, 3'b010);
        for (int i = 0; i < 4; i++) p(I_LW, 1'b0, MRD);
        for (int i = 0; i < 2; i++) p(I_LW, 1'b0, TRP);
        drain("mto");
        chk("mto_ret", 32'(bus.retired), 1);
        do_reset("mto_rst");

        // four stores, retired wraps 1,2,3,0
        for (int k = 0; k < 4; k++) begin
            p_sw();
            drain($sformatf("sw%0d", k));
            chk($sformatf("sw%0d_ret", k), 32'(bus.retired),
                32'((k + 1) % 4));
        end

        // reset during the second store's MEM cycle
        p_sw();
        drain("swa");
        chk("swa_ret", 32'(bus.retired), 1);
        p(I_SW, 1'b1, FET);
        p(I_SW, 1'b1, DEC);
        p_ex(I_SW, 1'b1, 3'b010);
        p(I_SW, 1'b0, MWW);
        drain("swb");
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk_v("swb_abort", obs(), NOOP, ALL);
        chk("swb_abort_ret", 32'(bus.retired), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("swb_after_ret", 32'(bus.retired), 0);

        p(I_ADD, 1'b1, FET);
        p(I_ADD, 1'b1, DEC);
        p_ex(I_ADD, 1'b0, 3'b010);
        p_wb(I_ADD, 2'b00, 1'b0);
        drain("post");
        chk("post_ret", 32'(bus.retired), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasserts, nfail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Parametrised multi-cycle control unit; replaces the hand-written per-opcode control settings in the single-cycle lab benches.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the control signals of yIF/yID/yEX/yDM/yWB from an FSM.
- Adds memory-ready handshake with wait states, a bus-timeout trap, an illegal-opcode trap and a retired-instruction counter.

Parameters:
- MEM_WAIT_MAX, 15, max cycles mem_ready may stay low in FETCH or MEM before a trap (1..255).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ins  in  32  instruction from yIF, sampled when ir_load=1.
- zero  in  1  ALU zero flag from yEX.
- mem_ready  in  1  memory handshake; 1 = current read/write completes this cycle.
- ir_load  out  1  latch the instruction register.
- pc_write  out  1  update the PC this cycle.
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jTarget.
- reg_write  out  1  register file write enable.
- alu_src  out  1  0 = rd2, 1 = imm.
- alu_op  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- mem_read  out  1  data/instruction memory read request.
- mem_write  out  1  data memory write request.
- mem2reg  out  1  writeback selects memOut.
- trap  out  1  sticky fault flag.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async): state=FETCH; wait counter, retired and trap = 0; all outputs 0 while rst=1.
- Outputs are combinational from state, the registered opcode class/funct and the inputs. Everything else is registered.
- FETCH:
  - mem_read=1 every cycle.
  - When mem_ready=1: ir_load=1 in the same cycle; opcode[6:0], funct3 and funct7[5] are latched; next state is DECODE.
- DECODE: classify the latched opcode.
  - 0x33 R-type, 0x13 I-ALU, 0x03 load, 0x23 store, 0x63 beq, 0x6F jal: go to EXEC.
  - Any other opcode: go to TRAP.
- EXEC: alu_src=0 for R-type and beq, 1 otherwise. alu_op decode:
  - R-type and I-ALU: funct3 000 → add (sub if R-type and funct7[5]=1); 111 → and; 110 → or; 010 → slt; other funct3 → TRAP.
  - Load and store: add.
  - beq: sub; pc_write=1; pc_sel=01 if zero=1, else 00; next state FETCH.
  - Load and store go to MEM; R-type, I-ALU and jal go to WB.
- MEM:
  - Load: mem_read=1. Store: mem_write=1. Both held until mem_ready=1.
  - Load then goes to WB.
  - Store completes in the mem_ready cycle: pc_write=1, pc_sel=00, next state FETCH.
- WB:
  - reg_write=1; mem2reg=1 only for load.
  - pc_write=1; pc_sel=10 for jal, else 00.
  - Next state FETCH.
- Minimum latency with mem_ready=1 throughout: R-type/I-ALU/jal 4 cycles, beq 3, store 4, load 5.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle mem_ready=0.
  - If it reaches MEM_WAIT_MAX with mem_ready still 0, go to TRAP. mem_ready=1 on the limit cycle wins.
- TRAP: trap=1; all other outputs 0; stays in TRAP until rst.
- retired:
  - Increments on every cycle with pc_write=1; wraps modulo 2^CNT_W.
  - Not incremented for trapped instructions.
- Reset asserted mid-instruction aborts it: no partial pc_write or reg_write after rst rises.

Decomposition:
- Shared package (constants):
  - Opcode constants: OP_R 0x33, OP_I 0x13, OP_LD 0x03, OP_ST 0x23, OP_BR 0x63, OP_JAL 0x6F.
  - ALU op codes.
  - pc_sel codes.
  - State encoding: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- One natural sub-module, mc_alu_decode: combinational funct3/funct7/class → alu_op plus an illegal flag.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 → FETCH,DECODE,EXEC,WB; alu_src=0 and alu_op=010 in EXEC; reg_write=1 and pc_write=1 only in WB; retired=1.
- lw x5,4(x0) (0x00402283), mem_ready low for 3 MEM cycles → mem_read held 4 MEM cycles; WB has mem2reg=1 and reg_write=1; total 8 cycles.
- beq x0,x0 (0x00000063), zero=1 → EXEC: alu_op=110, pc_write=1, pc_sel=01. Repeat with zero=0 → pc_sel=00. No reg_write either time.
- Illegal 0x00000000 → trap=1 from the cycle after DECODE, all enables 0 for 10+ cycles; rst pulse → trap=0, state FETCH.
- MEM_WAIT_MAX=4, mem_ready=0 in FETCH → trap rises after 4 FETCH cycles. Same run with mem_ready=1 on cycle 4 → no trap.
- CNT_W=2, four sw x1,0(x0) (0x00102023) back-to-back → retired sequence 1,2,3,0. Assert rst during the second instruction's MEM → retired=0, no mem_write after rst.
